// File: rtl/sram_fifo_controller_pkg.sv
// Shared sizing for the SRAM-backed FIFO controller and the RAM it drives.
package sram_fifo_controller_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 7;
  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
  localparam int unsigned STAGE_DEPTH = 2;

  typedef logic [1:0] stage_count_t;

endpackage

// File: rtl/sram_fifo_controller_if.sv
// Push/pop handshakes, RAM port and status of the SRAM FIFO controller.
interface sram_fifo_controller_if #(
  parameter int unsigned DATA_WIDTH = sram_fifo_controller_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = sram_fifo_controller_pkg::ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] pushData;
  logic                  pushValid;
  logic                  pushReady;
  logic [DATA_WIDTH-1:0] popData;
  logic                  popValid;
  logic                  popReady;
  logic [ADDR_WIDTH-1:0] ramWriteAddress;
  logic                  ramWriteEnable;
  logic [DATA_WIDTH-1:0] ramWriteData;
  logic [ADDR_WIDTH-1:0] ramReadAddress;
  logic [DATA_WIDTH-1:0] ramReadData;
  logic [ADDR_WIDTH:0]   level;
  logic                  empty;
  logic                  full;

  modport master (
    input  pushData, pushValid, popReady, ramReadData,
    output pushReady, popData, popValid, ramWriteAddress, ramWriteEnable, ramWriteData,
           ramReadAddress, level, empty, full
  );

  modport slave (
    output pushData, pushValid, popReady, ramReadData,
    input  pushReady, popData, popValid, ramWriteAddress, ramWriteEnable, ramWriteData,
           ramReadAddress, level, empty, full
  );

endinterface

// File: rtl/fifo_output_stage.sv
// Two-entry queue that catches RAM read data and presents the FIFO head.
module fifo_output_stage #(
  parameter int unsigned DATA_WIDTH = sram_fifo_controller_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);
  import sram_fifo_controller_pkg::*;

  logic [DATA_WIDTH-1:0] entry_q [STAGE_DEPTH];
  logic                  head_q;
  logic                  tail_q;
  stage_count_t          count_q;

  // The controller never sends data that would overflow, nor pops when empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '{default: '0};
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (in_valid) begin
        entry_q[tail_q] <= in_data;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + stage_count_t'(in_valid) - stage_count_t'(pop);
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = entry_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/sram_fifo_controller.sv
// FIFO whose storage is an external semi-dual-port RAM with 1-cycle registered read,
// fronted by a 2-entry output stage so the head is always available combinationally.
module sram_fifo_controller #(
  parameter int unsigned DATA_WIDTH = sram_fifo_controller_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = sram_fifo_controller_pkg::ADDR_WIDTH
) (
  input logic                    clock,
  input logic                    reset,
  sram_fifo_controller_if.master bus
);
  import sram_fifo_controller_pkg::*;

  localparam int unsigned FIFO_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned LEVEL_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0]  wptr_q;
  logic [ADDR_WIDTH-1:0]  rptr_q;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [LEVEL_WIDTH-1:0] unissued_q;
  logic                   inflight_q;

  logic                  push_ready;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  issue;
  logic [2:0]            occupancy;
  stage_count_t          out_count;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  // Handshake outputs come from registered level only, so a pop at full does not
  // open pushReady until the next cycle.
  assign push_ready = ~reset & (level_q != FULL_LEVEL);
  assign push_fire  = bus.pushValid & push_ready;
  assign pop_fire   = bus.popValid & bus.popReady;

  // Issue only while the output stage can absorb the word after this cycle's pop.
  assign occupancy = 3'(out_count) + 3'(inflight_q);
  assign issue     = (unissued_q != '0) && (occupancy < (pop_fire ? 3'd3 : 3'd2));

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      unissued_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (push_fire) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (issue) begin
        rptr_q <= rptr_q + 1'b1;
      end
      inflight_q <= issue;
      unissued_q <= unissued_q + LEVEL_WIDTH'(push_fire) - LEVEL_WIDTH'(issue);
      case ({push_fire, pop_fire})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  fifo_output_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_output_stage (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (bus.ramReadData),
    .pop       (pop_fire),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (out_count)
  );

  assign bus.pushReady       = push_ready;
  assign bus.popValid        = ~reset & out_valid;
  assign bus.popData         = reset ? '0 : out_data;
  assign bus.ramWriteEnable  = push_fire;
  assign bus.ramWriteAddress = wptr_q;
  assign bus.ramWriteData    = bus.pushData;
  assign bus.ramReadAddress  = rptr_q;
  assign bus.level           = reset ? '0 : level_q;
  assign bus.empty           = reset | (level_q == '0);
  assign bus.full            = ~reset & (level_q == FULL_LEVEL);

endmodule

// File: doc/sram_fifo_controller.md
SRAM_FIFO_CONTROLLER -- requirements
Module: sram_fifo_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, meaning RAM address width; depth = 2**ADDR_WIDTH = 128.
REQ-004 SHALL have ports: pushData  in  32  write word; pushValid  in  1  word offered; pushReady  out  1  word accepted when high with pushValid.
REQ-005 SHALL have ports: popData  out  32  head word; popValid  out  1  head valid; popReady  in  1  consumer takes head.
REQ-006 SHALL have ports: ramWriteAddress  out  7; ramWriteEnable  out  1; ramWriteData  out  32; ramReadAddress  out  7; ramReadData  in  32. These drive an external 128x32 semi-dual-port RAM clocked by clock, with 1-cycle registered read.
REQ-007 SHALL have ports: level  out  8  accepted-not-popped words (0..128); empty  out  1; full  out  1.

Function
REQ-008 SHALL define push fire = pushValid & pushReady, and pop fire = popValid & popReady.
REQ-009 SHALL drive pushReady = !full; full = (level == 128); empty = (level == 0). All three SHALL be derived from registered state only.
REQ-010 SHALL drive ramWriteEnable = push fire, ramWriteAddress = write pointer, and ramWriteData = pushData; the write pointer SHALL increment mod 128 on push fire.
REQ-011 SHALL keep an unissued count of words written but not yet read-issued; a read SHALL issue (ramReadAddress = read pointer, read pointer +1 mod 128) when unissued > 0 and (output entries + in-flight − pop fire) < 2.
REQ-012 SHALL give the output stage 2 entries; RAM data returning in cycle t+1 after issue SHALL be captured at the end of that cycle in FIFO order.
REQ-013 SHALL present popValid/popData from the output stage head, in strict push order.
REQ-014 Latency: push fire in cycle t into an empty FIFO SHALL give popValid = 1 in cycle t+3 with that word.
REQ-015 Throughput: with sustained push and pop and level >= 3, SHALL accept one push and deliver one pop per cycle.
REQ-016 level SHALL be +1 on push fire only, −1 on pop fire only, and unchanged on both.
REQ-017 At full, a simultaneous pop SHALL NOT make pushReady high in the same cycle; pushReady SHALL rise the next cycle.
REQ-018 When empty (popValid = 0), popReady SHALL be ignored; pushValid with pushReady low SHALL have no effect, with no RAM write.
REQ-019 Pointer wrap 127 -> 0 SHALL be seamless; same-cycle write and read of one address cannot occur, because issue requires a prior write cycle.
REQ-020 popData SHALL hold its value while popValid & !popReady.

Reset
REQ-021 While reset is high: pointers, unissued, in-flight, output stage and level SHALL be 0; popValid = 0; popData = 0; pushReady = 0; ramWriteEnable = 0.
REQ-022 Reset mid-operation SHALL discard all stored and in-flight words; RAM data returning after reset SHALL be dropped; RAM contents SHALL NOT be cleared.
REQ-023 The first cycle after reset deasserts SHALL have pushReady = 1, empty = 1, and level = 0.

Structure
REQ-024 DATA_WIDTH, ADDR_WIDTH and DEPTH (128) SHALL reside in a shared package/header used by this block and its RAM.
REQ-025 The 2-entry output queue SHALL be one sub-module, fifo_output_stage; the RAM SHALL stay outside this block.

Verification
REQ-026 Reset, then push 0xA5A5_0001 at cycle t -> popValid in t+3 with 0xA5A5_0001; level 1 -> 0 after pop.
REQ-027 Push 128 words 0..127 with popReady = 0 -> full = 1 and pushReady = 0 after the 128th; a 129th push is not written; popping yields 0..127 in order.
REQ-028 Fill to 128, pop one and offer a push in the same cycle -> push refused that cycle, accepted the next; level 127 -> 128.
REQ-029 Continuous push/pop for 300 words with popReady always high -> one word per cycle after priming, in order, correct across 2 pointer wraps.
REQ-030 Random popReady (50%) with 1000 words -> scoreboard match; popData stable while stalled; level never exceeds 128.
REQ-031 Assert reset with level = 5 and a read in flight -> popValid = 0 and level = 0 next cycle; a fresh push 0x1234 pops as 0x1234, with no stale data.
